// File: rtl/ysyx_23060201_arbiter.sv
// rtl/ysyx_23060201_arbiter.sv - two-master (IFU/LSU) memory arbiter with timeout
module ysyx_23060201_arbiter #(
    parameter int MEM_ADDR_WIDTH = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT        = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ifu_req_valid,
    output logic                      ifu_req_ready,
    input  logic [MEM_ADDR_WIDTH-1:0] ifu_req_addr,
    output logic                      ifu_resp_valid,
    output logic [DATA_WIDTH-1:0]     ifu_resp_data,
    output logic                      ifu_resp_err,
    input  logic                      lsu_req_valid,
    output logic                      lsu_req_ready,
    input  logic [MEM_ADDR_WIDTH-1:0] lsu_req_addr,
    input  logic                      lsu_req_wen,
    input  logic [DATA_WIDTH-1:0]     lsu_req_wdata,
    input  logic [7:0]                lsu_req_wmask,
    output logic                      lsu_resp_valid,
    output logic [DATA_WIDTH-1:0]     lsu_resp_data,
    output logic                      lsu_resp_err,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [MEM_ADDR_WIDTH-1:0] mem_req_addr,
    output logic                      mem_req_wen,
    output logic [DATA_WIDTH-1:0]     mem_req_wdata,
    output logic [7:0]                mem_req_wmask,
    input  logic                      mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]     mem_resp_data,
    input  logic                      mem_resp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    // Counter value seen in the last REQ/WAIT cycle before the abort fires.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    logic        last_grant;   // 1 = LSU was granted last
    logic        owner;        // 1 = LSU owns the outstanding transaction
    logic [15:0] cnt;

    logic        pick_lsu;
    logic        done;
    logic        timed_out;
    logic        resp_fire;
    logic [DATA_WIDTH-1:0] resp_data_n;
    logic        resp_err_n;

    // Arbitration and completion decode; a tie goes to the master not granted last.
    always_comb begin
        pick_lsu      = lsu_req_valid && (!ifu_req_valid || !last_grant);
        ifu_req_ready = !rst && (state == IDLE) && ifu_req_valid && !pick_lsu;
        lsu_req_ready = !rst && (state == IDLE) && pick_lsu;
        done          = ((state == REQ) && mem_req_ready && mem_resp_valid) ||
                        ((state == WAIT) && mem_resp_valid);
        timed_out     = (state != IDLE) && !done && (cnt == TIMEOUT_LAST);
        resp_fire     = done || timed_out;
        resp_data_n   = done ? mem_resp_data : '0;
        resp_err_n    = done ? mem_resp_err : 1'b1;
    end

    // Transaction FSM with registered memory request and one-cycle response pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            last_grant     <= 1'b1;
            owner          <= 1'b0;
            cnt            <= '0;
            mem_req_valid  <= 1'b0;
            mem_req_addr   <= '0;
            mem_req_wen    <= 1'b0;
            mem_req_wdata  <= '0;
            mem_req_wmask  <= '0;
            ifu_resp_valid <= 1'b0;
            ifu_resp_data  <= '0;
            ifu_resp_err   <= 1'b0;
            lsu_resp_valid <= 1'b0;
            lsu_resp_data  <= '0;
            lsu_resp_err   <= 1'b0;
        end else begin
            ifu_resp_valid <= 1'b0;
            ifu_resp_data  <= '0;
            ifu_resp_err   <= 1'b0;
            lsu_resp_valid <= 1'b0;
            lsu_resp_data  <= '0;
            lsu_resp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (ifu_req_ready || lsu_req_ready) begin
                        owner         <= pick_lsu;
                        last_grant    <= pick_lsu;
                        cnt           <= '0;
                        mem_req_valid <= 1'b1;
                        state         <= REQ;
                        if (pick_lsu) begin
                            mem_req_addr  <= lsu_req_addr;
                            mem_req_wen   <= lsu_req_wen;
                            mem_req_wdata <= lsu_req_wdata;
                            mem_req_wmask <= lsu_req_wmask;
                        end else begin
                            mem_req_addr  <= ifu_req_addr;
                            mem_req_wen   <= 1'b0;
                            mem_req_wdata <= '0;
                            mem_req_wmask <= 8'h0F;
                        end
                    end
                end
                REQ, WAIT: begin
                    cnt <= cnt + 16'd1;
                    if (resp_fire) begin
                        mem_req_valid <= 1'b0;
                        state         <= IDLE;
                        if (owner) begin
                            lsu_resp_valid <= 1'b1;
                            lsu_resp_data  <= resp_data_n;
                            lsu_resp_err   <= resp_err_n;
                        end else begin
                            ifu_resp_valid <= 1'b1;
                            ifu_resp_data  <= resp_data_n;
                            ifu_resp_err   <= resp_err_n;
                        end
                    end else if ((state == REQ) && mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= WAIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060201_arbiter.sv
// tb/tb_ysyx_23060201_arbiter.sv - directed self-checking bench for the IFU/LSU arbiter
module tb_ysyx_23060201_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready;
    logic [31:0] ifu_req_addr;
    logic        ifu_resp_valid;
    logic [31:0] ifu_resp_data;
    logic        ifu_resp_err;
    logic        lsu_req_valid, lsu_req_ready;
    logic [31:0] lsu_req_addr;
    logic        lsu_req_wen;
    logic [31:0] lsu_req_wdata;
    logic [7:0]  lsu_req_wmask;
    logic        lsu_resp_valid;
    logic [31:0] lsu_resp_data;
    logic        lsu_resp_err;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [31:0] mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        mem_resp_err;

    int n_tests = 0;
    int n_fail  = 0;

    ysyx_23060201_arbiter #(
        .MEM_ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
        .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data), .lsu_resp_err(lsu_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_err(mem_resp_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        ifu_req_valid = 0; ifu_req_addr = 32'h8000_0000;
        lsu_req_valid = 0; lsu_req_addr = 32'h8000_2000; lsu_req_wen = 0;
        lsu_req_wdata = 32'h0; lsu_req_wmask = 8'h0F;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0; mem_resp_err = 0;
        tick();
        tick();

        // reset state: readies gated even with both requests valid
        ifu_req_valid = 1; lsu_req_valid = 1;
        #1;
        check("rst_ready", {ifu_req_ready, lsu_req_ready}, 2'b00);
        check("rst_outs", {mem_req_valid, ifu_resp_valid, lsu_resp_valid, mem_req_addr, mem_req_wmask}, '0);
        ifu_req_valid = 0; lsu_req_valid = 0;
        rst = 0;
        tick();

        // ties after reset: IFU first, then alternate; back-to-back grants in pulse cycle
        ifu_req_addr = 32'h8000_0100; lsu_req_addr = 32'h8000_0200; lsu_req_wmask = 8'h0F;
        ifu_req_valid = 1; lsu_req_valid = 1;
        for (int k = 0; k < 4; k++) begin
            logic exp_ifu;
            exp_ifu = (k % 2 == 0);
            #1;
            check($sformatf("tie_ready_%0d", k), {ifu_req_ready, lsu_req_ready}, {exp_ifu, !exp_ifu});
            tick();
            if (exp_ifu) ifu_req_valid = 0; else lsu_req_valid = 0;
            check($sformatf("tie_addr_%0d", k), {mem_req_valid, mem_req_addr},
                  {1'b1, exp_ifu ? 32'h8000_0100 : 32'h8000_0200});
            mem_req_ready = 1; mem_resp_valid = 1; mem_resp_data = 32'h1000 + k;
            tick();
            mem_req_ready = 0; mem_resp_valid = 0;
            check($sformatf("tie_resp_%0d", k),
                  {ifu_resp_valid, lsu_resp_valid, exp_ifu ? ifu_resp_data : lsu_resp_data},
                  {exp_ifu, !exp_ifu, 32'h1000 + k});
            if (exp_ifu) ifu_req_valid = 1; else lsu_req_valid = 1;
        end
        ifu_req_valid = 0; lsu_req_valid = 0;
        tick();

        // LSU store with 5 stall cycles: payload must hold
        lsu_req_addr = 32'h8000_1000; lsu_req_wen = 1; lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wmask = 8'h03;
        lsu_req_valid = 1;
        #1;
        check("st_ready", {ifu_req_ready, lsu_req_ready}, 2'b01);
        tick();
        lsu_req_valid = 0; lsu_req_wdata = 32'h0; lsu_req_wen = 0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("st_hold_%0d", i), {mem_req_valid, mem_req_wen, mem_req_wmask, mem_req_addr, mem_req_wdata},
                  {1'b1, 1'b1, 8'h03, 32'h8000_1000, 32'hDEAD_BEEF});
            tick();
        end
        mem_req_ready = 1;
        check("st_hold_5", {mem_req_valid, mem_req_addr}, {1'b1, 32'h8000_1000});
        tick();
        mem_req_ready = 0;
        check("st_wait", {mem_req_valid, lsu_resp_valid}, 2'b00);
        mem_resp_valid = 1; mem_resp_data = 32'h0;
        tick();
        mem_resp_valid = 0;
        check("st_resp", {lsu_resp_valid, lsu_resp_err, ifu_resp_valid}, 3'b100);

        // IFU alone: ready after 1 cycle, response 2 cycles later
        ifu_req_addr = 32'h8000_0000; ifu_req_valid = 1;
        #1;
        check("if_ready", {ifu_req_ready, lsu_req_ready}, 2'b10);
        tick();
        ifu_req_valid = 0;
        check("if_req", {mem_req_valid, mem_req_wen, mem_req_wmask, mem_req_addr, mem_req_wdata},
              {1'b1, 1'b0, 8'h0F, 32'h8000_0000, 32'h0});
        mem_req_ready = 1;
        tick();
        mem_req_ready = 0;
        check("if_drop", mem_req_valid, 1'b0);
        tick();
        check("if_nopulse", ifu_resp_valid, 1'b0);
        mem_resp_valid = 1; mem_resp_data = 32'h0000_0413;
        tick();
        mem_resp_valid = 0; mem_resp_data = 32'h0;
        check("if_resp", {ifu_resp_valid, ifu_resp_err, ifu_resp_data, lsu_resp_valid}, {1'b1, 1'b0, 32'h0000_0413, 1'b0});
        tick();
        check("if_pulse_end", {ifu_resp_valid, ifu_resp_data}, 33'h0);

        // timeout: LSU load never answered, abort after 8 REQ/WAIT cycles
        lsu_req_addr = 32'h8000_3000; lsu_req_wmask = 8'h0F; lsu_req_valid = 1;
        tick();
        lsu_req_valid = 0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("to_pending_%0d", i), {mem_req_valid, lsu_resp_valid}, 2'b10);
            tick();
        end
        check("to_resp", {lsu_resp_valid, lsu_resp_err, lsu_resp_data, mem_req_valid, ifu_resp_valid},
              {1'b1, 1'b1, 32'h0, 1'b0, 1'b0});
        mem_resp_valid = 1; mem_resp_data = 32'h5555_5555;
        tick();
        mem_resp_valid = 0;
        check("to_late", {lsu_resp_valid, ifu_resp_valid, lsu_resp_data}, 34'h0);

        // reset during WAIT of an IFU transaction: no pulse, next tie goes to IFU
        ifu_req_addr = 32'h8000_4000; ifu_req_valid = 1;
        tick();
        ifu_req_valid = 0; mem_req_ready = 1;
        tick();
        mem_req_ready = 0;
        rst = 1; ifu_req_valid = 1; lsu_req_valid = 1;
        #1;
        check("rw_ready_in_rst", {ifu_req_ready, lsu_req_ready}, 2'b00);
        tick();
        rst = 0; mem_resp_valid = 1; mem_resp_data = 32'h7777_7777;
        check("rw_outs", {mem_req_valid, ifu_resp_valid, lsu_resp_valid, ifu_resp_data, mem_req_addr}, '0);
        #1;
        check("rw_tie", {ifu_req_ready, lsu_req_ready}, 2'b10);
        tick();
        mem_resp_valid = 0; ifu_req_valid = 0; lsu_req_valid = 0;
        check("rw_ignored", {ifu_resp_valid, lsu_resp_valid, mem_req_valid, mem_req_addr}, {3'b001, 32'h8000_4000});
        mem_req_ready = 1; mem_resp_valid = 1; mem_resp_data = 32'h0000_ABCD;
        tick();
        mem_req_ready = 0; mem_resp_valid = 0;
        check("rw_resp", {ifu_resp_valid, ifu_resp_data}, {1'b1, 32'h0000_ABCD});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
